// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch
// Byte-addressed instruction memory with a registered, handshaked fetch
// port and a byte-wide load port. Each accepted request returns one
// WORD_BYTES-wide instruction word on the following cycle, assembled
// big- or little-endian and tagged with a misalignment flag.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (response register only)
//   ld_en/ld_addr/ld_data  byte write into storage
//   req_valid/req_ready/req_addr  fetch request handshake
//   flush          drop the held response and any same-cycle request
//   rsp_valid/rsp_ready  response handshake
//   rsp_instr      fetched word
//   rsp_misaligned low address bits of the request were nonzero
//   rsp_addr       request address echoed with the response
module instr_mem_fetch #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [7:0]              ld_data,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic                    flush,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_instr,
  output logic                    rsp_misaligned,
  output logic [ADDR_W-1:0]       rsp_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WORD_W = 8 * WORD_BYTES;
  // Low address bits that must be zero for an aligned word; zero when WORD_BYTES=1.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Storage starts at zero and is deliberately untouched by rst_n.
  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic                misal_q, misal_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic                accept_s;
  logic [WORD_W-1:0]   word_s;
  logic [ADDR_W-1:0]   byte_addr_s;

  // Single response register, no skid buffer: ready whenever the slot drains.
  assign req_ready = (state_q == ST_EMPTY) || rsp_ready;
  assign accept_s  = req_valid && req_ready && !flush;

  assign rsp_valid      = (state_q == ST_FULL);
  assign rsp_instr      = instr_q;
  assign rsp_misaligned = misal_q;
  assign rsp_addr       = addr_q;

  // Byte store; loads are ignored while reset is asserted.
  always_ff @(posedge clk) begin
    if (ld_en && rst_n) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Assemble the addressed word from pre-write storage; addresses wrap.
  always_comb begin
    word_s      = '0;
    byte_addr_s = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      byte_addr_s = req_addr + ADDR_W'(k);
      if (BIG_ENDIAN) begin
        word_s[8*(WORD_BYTES-1-k) +: 8] = mem_q[byte_addr_s];
      end else begin
        word_s[8*k +: 8] = mem_q[byte_addr_s];
      end
    end
  end

  // Next-state and response payload selection.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    misal_d = misal_q;
    addr_d  = addr_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Flush wins over both drain and a same-cycle accept.
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (accept_s) begin
          state_d = ST_FULL;
        end else if (rsp_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (accept_s) begin
      instr_d = word_s;
      misal_d = |(req_addr & ALIGN_MASK);
      addr_d  = req_addr;
    end else begin
      instr_d = instr_q;
      misal_d = misal_q;
      addr_d  = addr_q;
    end
  end

  // Response register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      misal_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      misal_q <= misal_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a big-endian and a little-endian
// instance share all inputs and are checked against hand-computed words.
module tb_instr_mem_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic        flush;
  logic        rsp_ready;

  logic        be_req_ready, be_rsp_valid, be_rsp_mis;
  logic [31:0] be_rsp_instr;
  logic [7:0]  be_rsp_addr;
  logic        le_req_ready, le_rsp_valid, le_rsp_mis;
  logic [31:0] le_rsp_instr;
  logic [7:0]  le_rsp_addr;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  instr_mem_fetch #(.ADDR_W(8), .WORD_BYTES(4), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(be_req_ready), .req_addr(req_addr),
    .flush(flush), .rsp_valid(be_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(be_rsp_instr), .rsp_misaligned(be_rsp_mis), .rsp_addr(be_rsp_addr)
  );

  instr_mem_fetch #(.ADDR_W(8), .WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(le_req_ready), .req_addr(req_addr),
    .flush(flush), .rsp_valid(le_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(le_rsp_instr), .rsp_misaligned(le_rsp_mis), .rsp_addr(le_rsp_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Full response check on both instances.
  task automatic check_rsp(input string tag, input logic [31:0] be_w, input logic [31:0] le_w,
                           input logic mis, input logic [7:0] a);
    check({tag, "_be_valid"}, 64'(be_rsp_valid), 64'd1);
    check({tag, "_le_valid"}, 64'(le_rsp_valid), 64'd1);
    check({tag, "_be_instr"}, 64'(be_rsp_instr), 64'(be_w));
    check({tag, "_le_instr"}, 64'(le_rsp_instr), 64'(le_w));
    check({tag, "_be_mis"},   64'(be_rsp_mis),   64'(mis));
    check({tag, "_le_mis"},   64'(le_rsp_mis),   64'(mis));
    check({tag, "_be_addr"},  64'(be_rsp_addr),  64'(a));
    check({tag, "_le_addr"},  64'(le_rsp_addr),  64'(a));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_be_valid"}, 64'(be_rsp_valid), 64'd0);
    check({tag, "_le_valid"}, 64'(le_rsp_valid), 64'd0);
  endtask

  task automatic fetch(input logic [7:0] a);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    req_valid = 1'b0; req_addr = 8'h00; flush = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_be_ready", 64'(be_req_ready), 64'd1);
    check("rst_le_ready", 64'(le_req_ready), 64'd1);
    check_empty("rst");
    check("rst_instr", 64'(be_rsp_instr), 64'd0);
    check("rst_addr",  64'(be_rsp_addr),  64'd0);

    // Aligned fetch, both endiannesses.
    load(8'h10, 8'hDE); load(8'h11, 8'hAD); load(8'h12, 8'hBE); load(8'h13, 8'hEF);
    fetch(8'h10);
    check_rsp("aligned", 32'hDEADBEEF, 32'hEFBEADDE, 1'b0, 8'h10);
    tick();
    check_empty("drain1");

    // Asynchronous reset while holding a response.
    rsp_ready = 1'b0;
    fetch(8'h10);
    check("pre_rst_valid", 64'(be_rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_empty("async_rst");
    check("async_rst_instr", 64'(be_rsp_instr), 64'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("rel_ready", 64'(be_req_ready), 64'd1);
    tick();
    check_empty("rel_no_rsp");

    // Wrap around top of memory, misaligned.
    load(8'hFE, 8'h11); load(8'hFF, 8'h22); load(8'h00, 8'h33); load(8'h01, 8'h44);
    fetch(8'hFE);
    check_rsp("wrap", 32'h11223344, 32'h44332211, 1'b1, 8'hFE);
    tick();
    check_empty("drain2");

    // Backpressure: 0x04 must wait behind a stalled 0x00 response.
    load(8'h04, 8'h01); load(8'h05, 8'h02); load(8'h06, 8'h03); load(8'h07, 8'h04);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'h00;
    tick();
    req_addr = 8'h04;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 64'(be_req_ready), 64'd0);
      check_rsp("bp_hold", 32'h33440000, 32'h00004433, 1'b0, 8'h00);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_up", 64'(be_req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    check_rsp("bp_next", 32'h01020304, 32'h04030201, 1'b0, 8'h04);
    tick();
    check_empty("drain3");

    // Flush overrides a same-cycle accept while FULL.
    rsp_ready = 1'b0;
    fetch(8'h10);
    check("fl_full", 64'(be_rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'h08; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_empty("fl_gone");
      tick();
    end

    // Load/fetch collision: response sees the old byte.
    req_valid = 1'b1; req_addr = 8'h20;
    ld_en = 1'b1; ld_addr = 8'h21; ld_data = 8'hAA;
    tick();
    req_valid = 1'b0; ld_en = 1'b0;
    check_rsp("coll_old", 32'h00000000, 32'h00000000, 1'b0, 8'h20);
    fetch(8'h20);
    check_rsp("coll_new", 32'h00AA0000, 32'h0000AA00, 1'b0, 8'h20);
    tick();
    check_empty("drain4");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
